// File: rtl/fetch_pc_seq_pkg.sv
// Shared CPU definitions for the fetch sequencer: FSM encodings, PC step and
// branch opcode numbers that the branch decision unit also uses.
package fetch_pc_seq_pkg;

    typedef logic [1:0] fsm_state_t;

    localparam logic [1:0] FSM_IDLE  = 2'd0;
    localparam logic [1:0] FSM_FETCH = 2'd1;
    localparam logic [1:0] FSM_EXEC  = 2'd2;
    localparam logic [1:0] FSM_HALT  = 2'd3;

    localparam int PC_STEP = 4;

    // Branch opcodes decoded upstream; kept here so both units agree on numbering.
    localparam logic [5:0] BR_OP_BEQ  = 6'd15;
    localparam logic [5:0] BR_OP_BNE  = 6'd16;
    localparam logic [5:0] BR_OP_BLT  = 6'd17;
    localparam logic [5:0] BR_OP_BGE  = 6'd18;
    localparam logic [5:0] BR_OP_BLTU = 6'd19;
    localparam logic [5:0] BR_OP_BGEU = 6'd20;

endpackage

// File: rtl/fetch_pc_seq_target_calc.sv
// Combinational next-PC candidates: sequential, PC-relative branch and
// region-absolute jump. All sums wrap modulo 2^PC_W.
module pc_target_calc
    import fetch_pc_seq_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int OFF_W = 16
) (
    input  logic [PC_W-1:0]  pc,
    input  logic [OFF_W-1:0] branch_off,
    input  logic [25:0]      jump_tgt,
    output logic [PC_W-1:0]  pc_plus4,
    output logic [PC_W-1:0]  br_tgt,
    output logic [PC_W-1:0]  j_tgt
);

    logic signed [PC_W-1:0] off_ext;
    logic signed [PC_W-1:0] off_bytes;

    always_comb begin
        pc_plus4  = pc + PC_W'(PC_STEP);
        off_ext   = {{(PC_W-OFF_W){branch_off[OFF_W-1]}}, branch_off};
        off_bytes = off_ext <<< 2;
        br_tgt    = pc_plus4 + $unsigned(off_bytes);
        // Jump keeps the 256 MB region of the following instruction.
        j_tgt     = {pc_plus4[PC_W-1:28], jump_tgt, 2'b00};
    end

endmodule

// File: rtl/fetch_pc_seq.sv
// Program-counter and instruction-fetch sequencer: fetches one word per
// instruction over req/ack, then resolves halt/jump/branch/sequential in EXEC.
module fetch_pc_seq
    import fetch_pc_seq_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              OFF_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    input  logic              stall,
    input  logic              branch_en,
    input  logic [OFF_W-1:0]  branch_off,
    input  logic              jump_en,
    input  logic [25:0]       jump_tgt,
    input  logic              halt,
    output logic [PC_W-1:0]   pc_out,
    output logic              flush,
    output logic              halted
);

    fsm_state_t      state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] br_tgt;
    logic [PC_W-1:0] j_tgt;

    pc_target_calc #(
        .PC_W  (PC_W),
        .OFF_W (OFF_W)
    ) u_target_calc (
        .pc         (pc),
        .branch_off (branch_off),
        .jump_tgt   (jump_tgt),
        .pc_plus4   (pc_plus4),
        .br_tgt     (br_tgt),
        .j_tgt      (j_tgt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FSM_IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            flush       <= 1'b0;
            halted      <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            flush       <= 1'b0;
            case (state)
                FSM_IDLE: state <= FSM_FETCH;
                FSM_FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= FSM_EXEC;
                    end
                end
                FSM_EXEC: begin
                    // Halt outranks any redirect so a halting instruction never flushes.
                    if (!stall) begin
                        if (halt) begin
                            halted <= 1'b1;
                            state  <= FSM_HALT;
                        end else begin
                            state <= FSM_FETCH;
                            if (jump_en) begin
                                pc    <= j_tgt;
                                flush <= 1'b1;
                            end else if (branch_en) begin
                                pc    <= br_tgt;
                                flush <= 1'b1;
                            end else begin
                                pc <= pc_plus4;
                            end
                        end
                    end
                end
                FSM_HALT: state <= FSM_HALT;
                default:  state <= FSM_IDLE;
            endcase
        end
    end

    always_comb begin
        imem_req  = (state == FSM_FETCH);
        imem_addr = pc;
        pc_out    = pc;
    end

endmodule
